// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, the
// stage-control bundle with its fixed patterns, and the load-use detector.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_ERR      = 2'd2,
    HZ_ILLEGAL  = 2'd3
  } hz_state_e;

  // Per-stage control bundle. A NOP/bubble is expressed as a flush, never as data.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_flush;
    logic redirect_valid;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_CTRL_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_flush: 1'b0, redirect_valid: 1'b0
  };

  // Front of the pipe frozen; the only movement is a bubble falling into MEM/WB.
  localparam hz_ctrl_t HZ_CTRL_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_flush: 1'b1, redirect_valid: 1'b0
  };

  localparam hz_ctrl_t HZ_CTRL_OFF = '0;

  function automatic int hz_wait_w(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic hz_load_use(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2,
    input logic       ex_memread,
    input logic [4:0] ex_rd
  );
    return ex_memread && (ex_rd != 5'd0) &&
           ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hz_sat_counter.sv
// Saturating event counter: counts cycles with inc=1 and sticks at all-ones.
module hz_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, data-memory
// wait freezes with a sticky timeout, and EX redirects, plus saturating counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 1024,
  parameter int PC_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_redirect,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int              WAIT_W   = hz_wait_w(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  hz_ctrl_t          ctrl;
  logic              memwait;
  logic              load_use;

  assign memwait  = mem_req & ~mem_ready;
  assign load_use = hz_load_use(id_rs1, id_rs2, id_use_rs1, id_use_rs2,
                                id_ex_memread, id_ex_rd);

  always_comb begin
    ctrl          = HZ_CTRL_RUN;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      HZ_RUN, HZ_MEM_WAIT: begin
        if (memwait) begin
          // A frozen EX re-presents any redirect/load-use once memory completes.
          ctrl = HZ_CTRL_FREEZE;
          if (state_q == HZ_RUN) begin
            state_d    = HZ_MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_MAX)) begin
            state_d       = HZ_ERR;
            mem_timeout_d = 1'b1;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          state_d    = HZ_RUN;
          wait_cnt_d = '0;
          if (ex_redirect) begin
            ctrl.redirect_valid = 1'b1;
            ctrl.if_id_flush    = 1'b1;
            ctrl.id_ex_flush    = 1'b1;
          end else if (load_use) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end
        end
      end
      HZ_ERR: begin
        ctrl = HZ_CTRL_FREEZE;
      end
      default: begin
        ctrl       = HZ_CTRL_FREEZE;
        state_d    = HZ_RUN;
        wait_cnt_d = '0;
      end
    endcase
    if (!rst_n) begin
      ctrl = HZ_CTRL_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HZ_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~ctrl.pc_en),
    .count (stall_cycles)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.redirect_valid),
    .count (flush_events)
  );

  assign pc_en          = ctrl.pc_en;
  assign if_id_en       = ctrl.if_id_en;
  assign if_id_flush    = ctrl.if_id_flush;
  assign id_ex_en       = ctrl.id_ex_en;
  assign id_ex_flush    = ctrl.id_ex_flush;
  assign ex_mem_en      = ctrl.ex_mem_en;
  assign mem_wb_flush   = ctrl.mem_wb_flush;
  assign redirect_valid = ctrl.redirect_valid;
  assign redirect_pc    = ex_target;
  assign state          = state_q;
  assign mem_timeout    = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W       = 3;
  localparam int MEM_TIMEOUT = 4;
  localparam int PC_W        = 32;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int VEC_W       = 8 + PC_W + 2 + 1 + 2 * CNT_W;

  // Control vector order: pc_en, if_id_en, if_id_flush, id_ex_en,
  // id_ex_flush, ex_mem_en, mem_wb_flush, redirect_valid.
  localparam logic [7:0] C_NORMAL = 8'b1101_0100;
  localparam logic [7:0] C_LU     = 8'b0001_1100;
  localparam logic [7:0] C_REDIR  = 8'b1111_1101;
  localparam logic [7:0] C_FREEZE = 8'b0000_0010;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]       id_rs1, id_rs2, id_ex_rd;
  logic             id_use_rs1, id_use_rs2, id_ex_memread;
  logic             ex_redirect, mem_req, mem_ready;
  logic [PC_W-1:0]  ex_target;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic             ex_mem_en, mem_wb_flush, redirect_valid, mem_timeout;
  logic [PC_W-1:0]  redirect_pc;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  pipeline_hazard_ctrl #(
    .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .PC_W(PC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_flush(mem_wb_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .state(state), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  logic [7:0] dut_ctrl;
  assign dut_ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en,
                     id_ex_flush, ex_mem_en, mem_wb_flush, redirect_valid};

  // behavioural model: 0=running, 1=waiting on memory, 2=timed out
  int m_state = 0;
  int m_wait  = 0;
  int m_tout  = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic logic [7:0] model_ctrl();
    logic lu;
    if (!rst_n) return 8'b0;
    if (m_state == 2 || (mem_req && !mem_ready)) return C_FREEZE;
    if (ex_redirect) return C_REDIR;
    lu = id_ex_memread && (id_ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == id_ex_rd) || (id_use_rs2 && id_rs2 == id_ex_rd));
    if (lu) return C_LU;
    return C_NORMAL;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_wait <= 0; m_tout <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      if (!model_ctrl()[7] && m_stall < CNT_MAX) m_stall <= m_stall + 1;
      if (model_ctrl()[0] && m_flush < CNT_MAX) m_flush <= m_flush + 1;
      if (m_state != 2) begin
        if (mem_req && !mem_ready) begin
          if (m_state == 1 && m_wait == MEM_TIMEOUT) begin
            m_state <= 2;
            m_tout  <= 1;
          end else begin
            m_state <= 1;
            m_wait  <= (m_state == 0) ? 1 : m_wait + 1;
          end
        end else begin
          m_state <= 0;
          m_wait  <= 0;
        end
      end
    end
  end

  // scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  logic [VEC_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [VEC_W-1:0] got_v;
    logic [VEC_W-1:0] exp_v;
    exp_q.push_back({model_ctrl(), ex_target, 2'(m_state), 1'(m_tout),
                     CNT_W'(m_stall), CNT_W'(m_flush)});
    got_v = {dut_ctrl, redirect_pc, state, mem_timeout, stall_cycles, flush_events};
    exp_v = exp_q.pop_front();
    check("model", 64'(got_v), 64'(exp_v));
  endtask

  // driver tasks
  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_ex_memread = 1'b0; id_ex_rd = 5'd0; ex_redirect = 1'b0; ex_target = '0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic sample();
    @(negedge clk);
    compare_model();
  endtask

  task automatic set_lu_rs2(input logic [4:0] rd);
    id_ex_memread = 1'b1; id_ex_rd = rd; id_rs2 = rd; id_use_rs2 = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    compare_model();
    check("reset_ctrl", 64'(dut_ctrl), 64'(0));
    check("reset_state", 64'(state), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    set_idle();

    // load-use on rs2: one bubble, then none for x0
    do_reset();
    next_cycle(); set_lu_rs2(5'd5); sample();
    check("lu_ctrl", 64'(dut_ctrl), 64'(C_LU));
    check("lu_stall_before", 64'(stall_cycles), 64'(0));
    next_cycle(); sample();
    check("lu_one_bubble", 64'(pc_en), 64'(1));
    check("lu_stall_cnt", 64'(stall_cycles), 64'(1));
    next_cycle(); set_lu_rs2(5'd0); sample();
    check("lu_x0", 64'(dut_ctrl), 64'(C_NORMAL));

    // redirect beats load-use
    do_reset();
    next_cycle(); set_lu_rs2(5'd5); ex_redirect = 1'b1; ex_target = 32'h0000_0040; sample();
    check("redir_ctrl", 64'(dut_ctrl), 64'(C_REDIR));
    check("redir_pc", 64'(redirect_pc), 64'h40);
    next_cycle(); sample();
    check("redir_flush_cnt", 64'(flush_events), 64'(1));
    check("redir_stall_cnt", 64'(stall_cycles), 64'(0));

    // zero-wait access, then three wait cycles
    do_reset();
    next_cycle(); mem_req = 1'b1; mem_ready = 1'b1; sample();
    check("zw_ctrl", 64'(dut_ctrl), 64'(C_NORMAL));
    for (int i = 0; i < 3; i++) begin
      next_cycle(); mem_req = 1'b1; sample();
      check("mw_freeze", 64'(dut_ctrl), 64'(C_FREEZE));
      check("mw_state", 64'(state), 64'((i == 0) ? 0 : 1));
    end
    next_cycle(); mem_req = 1'b1; mem_ready = 1'b1; sample();
    check("mw_release", 64'(dut_ctrl), 64'(C_NORMAL));
    next_cycle(); sample();
    check("mw_state_run", 64'(state), 64'(0));
    check("mw_stall_cnt", 64'(stall_cycles), 64'(3));

    // redirect held during a memory wait
    do_reset();
    for (int i = 0; i < 2; i++) begin
      next_cycle(); mem_req = 1'b1; ex_redirect = 1'b1; ex_target = 32'h80; sample();
      check("mwr_suppressed", 64'(redirect_valid), 64'(0));
    end
    next_cycle(); mem_req = 1'b1; mem_ready = 1'b1; ex_redirect = 1'b1; ex_target = 32'h80; sample();
    check("mwr_fires", 64'(dut_ctrl), 64'(C_REDIR));
    next_cycle(); sample();
    check("mwr_once", 64'(redirect_valid), 64'(0));
    check("mwr_flush_cnt", 64'(flush_events), 64'(1));

    // timeout into the sticky error state, then asynchronous reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      next_cycle(); mem_req = 1'b1; sample();
    end
    next_cycle(); mem_req = 1'b1; sample();
    check("to_state", 64'(state), 64'(2));
    check("to_flag", 64'(mem_timeout), 64'(1));
    next_cycle(); ex_redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b1; sample();
    check("err_ctrl", 64'(dut_ctrl), 64'(C_FREEZE));
    check("err_stall_cnt", 64'(stall_cycles), 64'(6));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", 64'(state), 64'(0));
    check("arst_flag", 64'(mem_timeout), 64'(0));
    check("arst_stall", 64'(stall_cycles), 64'(0));
    check("arst_ctrl", 64'(dut_ctrl), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // counter saturation
    do_reset();
    for (int i = 0; i < 10; i++) begin
      next_cycle(); set_lu_rs2(5'd7); sample();
    end
    next_cycle(); sample();
    check("sat_stall", 64'(stall_cycles), 64'(CNT_MAX));

    // randomized traffic
    begin
      int slow;
      slow = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(posedge clk);
        #1;
        if (!rst_n) rst_n = 1'b1;
        else if ($urandom_range(0, 59) == 0) rst_n = 1'b0;
        if ($urandom_range(0, 31) == 0) slow = $urandom_range(0, 1);
        id_rs1        = 5'($urandom_range(0, 3));
        id_rs2        = 5'($urandom_range(0, 3));
        id_ex_rd      = 5'($urandom_range(0, 3));
        id_use_rs1    = 1'($urandom_range(0, 1));
        id_use_rs2    = 1'($urandom_range(0, 1));
        id_ex_memread = 1'($urandom_range(0, 1));
        ex_redirect   = ($urandom_range(0, 3) == 0);
        ex_target     = $urandom;
        mem_req       = ($urandom_range(0, 2) != 0);
        mem_ready     = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        sample();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It works alongside the forwarding unit and covers the hazards forwarding cannot resolve:
- load-use dependencies
- multi-cycle data-memory accesses
- EX-stage control redirects

It drives the enable/flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It keeps saturating performance counters and a sticky memory-timeout error.

Parameters:
CNT_W, 32, width of the stall_cycles and flush_events counters
MEM_TIMEOUT, 1024, consecutive wait cycles before the error state is entered; 0 disables the timeout
PC_W, 32, redirect PC width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset, asynchronous, active-low
id_rs1  in  5  source register 1 of the instruction in ID
id_rs2  in  5  source register 2 of the instruction in ID
id_use_rs1  in  1  instruction in ID reads rs1
id_use_rs2  in  1  instruction in ID reads rs2
id_ex_memread  in  1  instruction in EX is a load
id_ex_rd  in  5  destination register of the instruction in EX
ex_redirect  in  1  taken branch or jump resolved in EX
ex_target  in  PC_W  redirect target
mem_req  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes this cycle (zero-wait is allowed)
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID loads a NOP
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX loads a bubble
ex_mem_en  out  1  EX/MEM load enable
mem_wb_flush  out  1  MEM/WB loads a bubble
redirect_valid  out  1  PC mux selects redirect_pc
redirect_pc  out  PC_W  equals ex_target
state  out  2  FSM state (debug)
mem_timeout  out  1  sticky error flag
stall_cycles  out  CNT_W  cycles with pc_en=0 after reset
flush_events  out  CNT_W  cycles with redirect_valid=1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, counters=0, wait_cnt=0, mem_timeout=0.
  - All enables, flushes and redirect_valid are 0.
  - Reset asserted mid-wait discards the wait with no residue.
- States:
  - RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2.
  - 2'd3 is illegal and returns to RUN on the next clock.
- Priority in RUN/MEM_WAIT (highest first); the default is all enables 1, flushes 0:
  1. memwait = mem_req & ~mem_ready. It freezes PC, IF/ID, ID/EX and EX/MEM (all en=0) and sets mem_wb_flush=1. Redirect and load-use are suppressed; the frozen EX re-presents them later.
  2. ex_redirect. Sets redirect_valid=1, pc_en=1, if_id_flush=1, id_ex_flush=1.
  3. load-use: id_ex_memread & id_ex_rd!=0 & ((id_use_rs1 & id_rs1==id_ex_rd) | (id_use_rs2 & id_rs2==id_ex_rd)). Sets pc_en=0, if_id_en=0, id_ex_flush=1. This produces exactly one bubble, because the load advances on the next cycle.
- Redirect and load-use in the same cycle: redirect wins, since the dependent instruction is killed.
- Transitions:
  - RUN→MEM_WAIT when memwait; wait_cnt is set to 1.
  - MEM_WAIT stays while memwait; wait_cnt increments.
  - MEM_WAIT→RUN in the cycle mem_ready=1. That cycle applies priorities 2 and 3 normally; wait_cnt=0.
  - MEM_WAIT→ERR when MEM_TIMEOUT!=0 and memwait holds with wait_cnt==MEM_TIMEOUT. mem_timeout is set to 1.
  - ERR is absorbing until reset: all enables 0, mem_wb_flush=1, redirect_valid=0.
- Counters:
  - Increment on the clock edge at the end of the qualifying cycle.
  - Saturate at all-ones; no wrap.
  - stall_cycles also counts ERR cycles.
- wait_cnt width is clog2(MEM_TIMEOUT+1), minimum 1 bit.
- All datapath outputs are combinational from inputs plus state. No output-to-input combinational loop exists: en/flush do not depend on each other.

Decomposition:
- defines.vh: state encodings (HZ_RUN, HZ_MEM_WAIT, HZ_ERR) and the NOP/bubble convention constants.
- One sub-module, hz_sat_counter (parameter W; inputs clk, rst_n, inc; output count). It is instantiated twice, for stall_cycles and flush_events.

Test Plan:
- Load-use, rs2 path: id_ex_memread=1, id_ex_rd=5, id_rs2=5, id_use_rs2=1 → exactly 1 cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1. Repeat with id_ex_rd=0 → no stall.
- Redirect beats load-use: load-use condition plus ex_redirect=1, ex_target=0x0000_0040 → redirect_valid=1, redirect_pc=0x40, pc_en=1, if_id_flush=id_ex_flush=1; flush_events=1, stall_cycles=0.
- Zero-wait memory: mem_req=1, mem_ready=1 → state stays RUN, no freeze. Then mem_req=1 with ready low for 3 cycles → 3 frozen cycles with mem_wb_flush=1, state=1; the 4th cycle (ready=1) advances and state=0; stall_cycles=3.
- Redirect during memwait: ex_redirect=1 while memwait → redirect_valid=0 until the ready cycle, then 1 for that cycle only.
- Timeout: MEM_TIMEOUT=4, mem_req=1, ready never → state=2 and mem_timeout=1 after 5 wait cycles; enables stay 0 thereafter. Pulse rst_n low mid-ERR → state=0, mem_timeout=0, counters=0 immediately, without a clock edge.
- Saturation: CNT_W=3 with continuous load-use for 10 cycles → stall_cycles holds at 7.
